// File: rtl/edge_frame_writer_pkg.sv
// Shared image-path definitions: capture FSM states and address sizing helper.
package edge_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_frame_writer_sync_fifo.sv
// Small synchronous FIFO holding {address, data} write entries; a pop frees the
// slot for a same-cycle push even when full.
module sync_fifo
  import edge_frame_writer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int PW = addr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/edge_frame_writer.sv
// Captures one frame from a non-stallable filtered pixel stream, zeroes the
// border pixels and writes every pixel to memory through a small FIFO.
module edge_frame_writer
  import edge_frame_writer_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 10,
  parameter int NUM_ROWS   = 10,
  parameter int SKIP       = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [WORD_SIZE-1:0]                        inputPixel,
  output logic                                        memValid,
  input  logic                                        memReady,
  output logic [addr_width(ROW_SIZE*NUM_ROWS)-1:0]    memAddr,
  output logic [WORD_SIZE-1:0]                        memData,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        overflow
);

  localparam int NPIX = ROW_SIZE * NUM_ROWS;
  localparam int AW   = addr_width(NPIX);
  localparam int SW   = addr_width(SKIP + 1);
  localparam int CW   = addr_width(ROW_SIZE);
  localparam int RW   = addr_width(NUM_ROWS);
  localparam int FW   = AW + WORD_SIZE;
  localparam int LW   = $clog2(FIFO_DEPTH + 1);

  state_t         state_q, state_d;
  logic [SW-1:0]  skip_cnt_q;
  logic [AW-1:0]  addr_q;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic           done_q, ovf_q;

  logic           start_acc, last_pix, last_pop;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LW-1:0]  fifo_level;
  logic [FW-1:0]  fifo_din, fifo_dout;

  function automatic logic is_border(input logic [CW-1:0] c, input logic [RW-1:0] r);
    return (c == '0) || (c == CW'(ROW_SIZE - 1)) || (r == '0) || (r == RW'(NUM_ROWS - 1));
  endfunction

  assign start_acc = (state_q == ST_IDLE) && start;
  assign last_pix  = (addr_q == AW'(NPIX - 1));
  assign fifo_push = (state_q == ST_CAPTURE);
  assign fifo_pop  = memValid && memReady;
  assign last_pop  = fifo_pop && (fifo_level == LW'(1));
  assign fifo_din  = {addr_q, is_border(col_q, row_q) ? '0 : inputPixel};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Empty FIFO shows zeros so the write port is clean after reset.
  assign memValid = !fifo_empty;
  assign memAddr  = fifo_empty ? '0 : fifo_dout[FW-1:WORD_SIZE];
  assign memData  = fifo_empty ? '0 : fifo_dout[WORD_SIZE-1:0];
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
      ST_SKIP:    if (skip_cnt_q == SW'(SKIP - 1)) state_d = ST_CAPTURE;
      ST_CAPTURE: if (last_pix) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty || last_pop) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= '0;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      if (start_acc) begin
        skip_cnt_q <= '0;
        addr_q     <= '0;
        col_q      <= '0;
        row_q      <= '0;
        ovf_q      <= 1'b0;
      end
      if (state_q == ST_SKIP) skip_cnt_q <= skip_cnt_q + 1'b1;
      // Counters advance on every capture pixel, dropped or not, so addresses stay aligned.
      if (state_q == ST_CAPTURE) begin
        addr_q <= addr_q + 1'b1;
        if (col_q == CW'(ROW_SIZE - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (fifo_full && !fifo_pop) ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/edge_frame_writer.md
EDGE_FRAME_WRITER -- requirements
Module: edge_frame_writer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, pixel width in bits.
REQ-002 SHALL have parameter ROW_SIZE, default 10, pixels per image row.
REQ-003 SHALL have parameter NUM_ROWS, default 10, rows per frame.
REQ-004 SHALL have parameter SKIP, default 13, number of stream pixels after start discarded as filter pipeline fill.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two, entries of the write-side buffer.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clock  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse; frame capture begins with the inputPixel sampled on the next edge.
REQ-010 inputPixel  in  WORD_SIZE  filtered pixel stream, one pixel per clock, no stall capability.
REQ-011 memValid  out  1  write request valid.
REQ-012 memReady  in  1  memory accepts write when memValid and memReady both high at a rising edge.
REQ-013 memAddr  out  clog2(ROW_SIZE*NUM_ROWS)  linear write address, row-major.
REQ-014 memData  out  WORD_SIZE  write data.
REQ-015 busy  out  1  high from the cycle after start until done.
REQ-016 done  out  1  one-cycle pulse when the last write is accepted.
REQ-017 overflow  out  1  sticky error: a capture pixel arrived with the FIFO full.

Function
REQ-018 SHALL implement FSM states IDLE, SKIP, CAPTURE, DRAIN; IDLE->SKIP on start; SKIP->CAPTURE after SKIP pixels counted; CAPTURE->DRAIN after ROW_SIZE*NUM_ROWS pixels pushed; DRAIN->IDLE when FIFO empty and last write accepted.
REQ-019 SHALL go IDLE->CAPTURE directly when SKIP=0.
REQ-020 SHALL ignore start while not IDLE.
REQ-021 SHALL in CAPTURE push exactly one {address, data} entry per clock, address incrementing 0 .. ROW_SIZE*NUM_ROWS-1 with column counter wrapping at ROW_SIZE and row counter incrementing on wrap.
REQ-022 SHALL replace data with 0 for border pixels (column 0, column ROW_SIZE-1, row 0, row NUM_ROWS-1); address still written.
REQ-023 SHALL present FIFO head on memAddr/memData with memValid high whenever FIFO non-empty; outputs stable while memValid high and memReady low.
REQ-024 SHALL, on a push to a full FIFO, drop that pixel, set overflow, still advance the address counters.
REQ-025 SHALL allow simultaneous push and pop when full (pop frees the slot, push not dropped).
REQ-026 SHALL pulse done the cycle after the final accepted write, with busy falling that same cycle.
REQ-027 overflow SHALL clear only on reset or on an accepted start.
REQ-028 SHALL have zero-cycle pop-to-memValid latency: push at edge N makes data visible at memValid after edge N when FIFO was empty.

Reset
REQ-029 SHALL on reset force state IDLE, counters 0, FIFO empty, memValid 0, busy 0, done 0, overflow 0, memAddr 0, memData 0.
REQ-030 SHALL abandon a frame mid-operation on reset; no further writes issued.

Structure
REQ-031 SHALL place the FSM state enum and the address-width function in a shared image package.
REQ-032 SHALL instantiate one sub-module sync_fifo (parameters width, depth; push/pop/full/empty) holding {address, data}.

Verification
REQ-033 ROW_SIZE=4,NUM_ROWS=3,SKIP=2, memReady=1, stream 1,2,3,... -> 12 writes, addr 0..11, data 0 except addr 5->8 and addr 6->9; done one cycle after addr 11 accepted.
REQ-034 Same setup, memReady low cycles 3-4 of CAPTURE, FIFO_DEPTH=4 -> no overflow, all 12 writes in order, memAddr/memData held while stalled.
REQ-035 memReady held low for whole capture -> overflow set on 5th capture pixel, first 4 entries (addr 0..3) written after memReady rises, done still pulses.
REQ-036 Reset asserted during CAPTURE -> next cycle memValid=0, busy=0, no done; subsequent start produces a complete correct frame.
REQ-037 start pulsed again while busy -> ignored, frame addresses unchanged, single done.
REQ-038 SKIP=0 -> first stream pixel after start written to addr 0.
